sub_serial: RTL and testbench
=============================

# sub_serial

Multi-cycle digit-serial subtractor computing `a - b - bin` over `DATA_WIDTH` bits, DIGIT_WIDTH bits per clock, with a borrow-out MSB. It is the inverse companion of the combinational ripple-carry adder. Feeding `diff_ext[DATA_WIDTH-1:0]`, `b` and `bin` into that adder returns `a`, and the adder's carry-out equals this block's borrow-out. Valid/ready handshakes on both sides let the block sit between a stimulus/operand source and a result consumer in the adder IP datapath.

## Interface
Single clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `DATA_WIDTH`, default 32: operand width.
- `DIGIT_WIDTH`, default 8: bits processed per cycle. Must divide `DATA_WIDTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `a`  in  DATA_WIDTH  minuend.
- `b`  in  DATA_WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `diff_ext`  out  DATA_WIDTH+1  `{borrow_out, difference}`.
- `ovf`  out  1  signed overflow. Present only with `SUB_SERIAL_OVF_EN`.

## Operation
- NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH. NUM_DIGITS = 1 is legal.
- FSM states:
  - IDLE: go to RUN on `in_valid && in_ready`.
  - RUN: go to DONE after the digit counter reaches NUM_DIGITS-1.
  - DONE: go to IDLE on `out_valid && out_ready`.
- Accept: latch `a`, `b`, `bin` into internal registers; clear the digit counter; load the running borrow with `bin`. Port changes after accept are ignored.
- RUN: one digit per cycle, LSB digit first. Compute digit = a_d - b_d - borrow and store it at its position in the result register. The slice's borrow-out becomes the next digit's borrow.
- Result: `diff_ext[DATA_WIDTH-1:0]` = (a - b - bin) mod 2^DATA_WIDTH. `diff_ext[DATA_WIDTH]` = 1 iff a < b + bin (unsigned).
- `in_ready` = (state == IDLE) && !rst. `out_valid` = (state == DONE).
- `diff_ext` (and `ovf`) are stable from the first `out_valid` cycle until the output handshake, and hold their value in IDLE until the next result.

## Timing
- Reset values: state IDLE, `out_valid`=0, `in_ready`=0 during reset, `diff_ext`=0, `ovf`=0, counter=0.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Accept at edge T gives RUN during T..T+NUM_DIGITS. `out_valid` rises at edge T+NUM_DIGITS, a latency of NUM_DIGITS cycles.
- Earliest output handshake is edge T+NUM_DIGITS+1. Earliest next accept is the following edge.
- Peak throughput is 1 op per NUM_DIGITS+2 cycles.
- Backpressure: with `out_ready`=0, DONE holds indefinitely, `in_ready` stays 0 and `in_valid` is ignored.
- Reset mid-RUN or mid-DONE aborts the operation. No `out_valid` pulse is produced and the result is discarded (`diff_ext`=0).
- `in_valid` asserted while `rst` is high is not accepted.

## Configuration
- `SUB_SERIAL_OVF_EN` defined:
  - `ovf` port exists, registered with the final digit.
  - `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), where a and b are the latched operands.
  - `bin` is included in diff.
- `SUB_SERIAL_OVF_EN` undefined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Shared package `adder_pkg`:
  - state enum `sub_state_e` {IDLE, RUN, DONE};
  - default width constants;
  - a function computing NUM_DIGITS and the counter width as max(1, $clog2(NUM_DIGITS)).
- Sub-module `sub_digit`: a combinational DIGIT_WIDTH-bit borrow-ripple slice with inputs x, y, bin and outputs d, bout. Per bit: d = x^y^bin, bout = (~x&y) | (~x&bin) | (y&bin). `sub_serial` instantiates it once.
- Elaboration check: fatal error if DATA_WIDTH % DIGIT_WIDTH != 0.

## Test plan
All scenarios use DATA_WIDTH=32, DIGIT_WIDTH=8, NUM_DIGITS=4.
1. a=10, b=3, bin=0, `out_ready`=1 → `diff_ext`=0x0_00000007; `out_valid` 4 cycles after accept, high 1 cycle; `in_ready` returns next cycle.
2. a=0, b=1, bin=0 → `diff_ext`=0x1_FFFFFFFF. Also a=5, b=5, bin=1 → 0x1_FFFFFFFF.
3. Cross-digit borrow: a=0x01000000, b=1, bin=0 → 0x0_00FFFFFF. Also a=0x00000100, b=0, bin=1 → 0x0_000000FF.
4. Backpressure: hold `out_ready`=0 for 10 cycles, toggle `a`/`b`, pulse `in_valid` → `out_valid` and `diff_ext` held, `in_ready`=0, no second accept; release → single handshake.
5. Assert `rst` 2 cycles after accept → no `out_valid`, outputs at reset values, `in_ready`=1 the cycle after release; next op a=100, b=1 gives 0x0_00000063.
6. With `SUB_SERIAL_OVF_EN`: a=0x80000000, b=1 → 0x0_7FFFFFFF, `ovf`=1; a=0x7FFFFFFF, b=0xFFFFFFFF → 0x1_80000000, `ovf`=1; a=5, b=5 → 0, `ovf`=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder IP datapath.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } sub_state_e;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_DIGIT_WIDTH = 8;

   function automatic int num_digits(input int data_width, input int digit_width);
      return data_width / digit_width;
   endfunction

   // A single-digit configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int data_width, input int digit_width);
      int n;
      n = $clog2(data_width / digit_width);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational borrow-ripple subtractor slice: d = x - y - bin over W bits.
module sub_digit #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic [W-1:0] d,
   output logic         bout
);

   always_comb begin
      logic br;
      br = bin;
      d  = '0;
      for (int i = 0; i < W; i++) begin
         d[i] = x[i] ^ y[i] ^ br;
         br   = (~x[i] & y[i]) | (~x[i] & br) | (y[i] & br);
      end
      bout = br;
   end

endmodule

// File: rtl/sub_serial.sv
// Digit-serial subtractor a - b - bin with borrow-out; one DIGIT_WIDTH slice per clock.
// Define SUB_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module sub_serial
   import adder_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DIGIT_WIDTH = DEF_DIGIT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH:0]   diff_ext
`ifdef SUB_SERIAL_OVF_EN
   ,
   output logic                  ovf
`endif
);

   localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
   localparam int CNT_W      = cnt_width(DATA_WIDTH, DIGIT_WIDTH);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

   if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_width_check
      $fatal(1, "sub_serial: DIGIT_WIDTH must divide DATA_WIDTH");
   end

   sub_state_e                       state;
   logic [DATA_WIDTH-1:0]            a_q;
   logic [DATA_WIDTH-1:0]            b_q;
   logic [DATA_WIDTH-1:0]            res_q;
   logic [DATA_WIDTH-1:0]            res_next;
   logic [DATA_WIDTH+DIGIT_WIDTH-1:0] res_cat;
   logic                             borrow_q;
   logic [CNT_W-1:0]                 cnt_q;
   logic [DIGIT_WIDTH-1:0]           d_digit;
   logic                             bout_digit;
`ifdef SUB_SERIAL_OVF_EN
   logic                             a_msb_q;
   logic                             b_msb_q;
`endif

   // Operands shift right so the active digit is always the low slice;
   // finished digits enter res_q from the top and land in place after NUM_DIGITS steps.
   sub_digit #(.W(DIGIT_WIDTH)) u_digit (
      .x    (a_q[DIGIT_WIDTH-1:0]),
      .y    (b_q[DIGIT_WIDTH-1:0]),
      .bin  (borrow_q),
      .d    (d_digit),
      .bout (bout_digit)
   );

   assign res_cat  = {d_digit, res_q};
   assign res_next = res_cat[DATA_WIDTH+DIGIT_WIDTH-1:DIGIT_WIDTH];

   // Handshake: a transfer happens on a rising edge where valid && ready; the
   // producer holds valid (and data) until then, and ready never depends on valid.
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_ext <= '0;
`ifdef SUB_SERIAL_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
`ifdef SUB_SERIAL_OVF_EN
                  a_msb_q  <= a[DATA_WIDTH-1];
                  b_msb_q  <= b[DATA_WIDTH-1];
`endif
                  state    <= RUN;
               end
            end
            RUN: begin
               a_q      <= a_q >> DIGIT_WIDTH;
               b_q      <= b_q >> DIGIT_WIDTH;
               res_q    <= res_next;
               borrow_q <= bout_digit;
               if (cnt_q == LAST_DIGIT) begin
                  diff_ext <= {bout_digit, res_next};
`ifdef SUB_SERIAL_OVF_EN
                  ovf      <= (a_msb_q != b_msb_q) && (res_next[DATA_WIDTH-1] != a_msb_q);
`endif
                  state    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial (DATA_WIDTH=32, DIGIT_WIDTH=8).
// Overflow checks are active when SUB_SERIAL_OVF_EN is defined.
module tb_sub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [32:0] diff_ext;
`ifdef SUB_SERIAL_OVF_EN
   logic        ovf;
`endif

   int checks   = 0;
   int failures = 0;
   logic [33:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   sub_serial #(.DATA_WIDTH(32), .DIGIT_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff_ext  (diff_ext)
`ifdef SUB_SERIAL_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       input logic [33:0] ev);
      int n;
      exp_q.push_back(ev);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", {33'd0, in_ready}, 34'd1);
      a        = av;
      b        = bv;
      bin      = bi;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      bin      = 1'($urandom_range(0, 1));
   endtask

   // Called 1ns after the accept edge; returns 1ns after out_valid rises.
   task automatic wait_out(input string tag, input int exp_lat);
      int          lat;
      logic [33:0] ev;
      logic [33:0] obs;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 34'(lat), 34'(exp_lat));
      ev = exp_q.pop_front();
`ifdef SUB_SERIAL_OVF_EN
      obs = {ovf, diff_ext};
`else
      obs = {1'b0, diff_ext};
      ev[33] = 1'b0;
`endif
      chk({tag, "_diff_ext"}, obs, ev);
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input logic [32:0] ed, input logic eo);
      send(av, bv, bi, {eo, ed});
      wait_out(tag, 4);
      @(posedge clk);
      #1;
      chk({tag, "_valid_one_cycle"}, {33'd0, out_valid}, 34'd0);
      chk({tag, "_in_ready_back"}, {33'd0, in_ready}, 34'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {33'd0, in_ready}, 34'd0);
      chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
      chk("rst_diff_ext", {1'b0, diff_ext}, 34'd0);
`ifdef SUB_SERIAL_OVF_EN
      chk("rst_ovf", {33'd0, ovf}, 34'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", {33'd0, in_ready}, 34'd1);

      // basic, underflow and cross-digit borrow cases
      run_op("basic",      32'd10,         32'd3,          1'b0, 33'h0_00000007, 1'b0);
      run_op("underflow",  32'd0,          32'd1,          1'b0, 33'h1_FFFFFFFF, 1'b0);
      run_op("bin_under",  32'd5,          32'd5,          1'b1, 33'h1_FFFFFFFF, 1'b0);
      run_op("xdigit_b",   32'h01000000,   32'd1,          1'b0, 33'h0_00FFFFFF, 1'b0);
      run_op("xdigit_bin", 32'h00000100,   32'd0,          1'b1, 33'h0_000000FF, 1'b0);
      run_op("all_ones",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 33'h1_FFFFFFFF, 1'b0);
      run_op("max_m_bin",  32'hFFFFFFFF,   32'd0,          1'b1, 33'h0_FFFFFFFE, 1'b0);

      // backpressure: DONE holds, inputs ignored, single handshake on release
      out_ready = 1'b0;
      send(32'h12345678, 32'h11111111, 1'b0, {1'b0, 33'h0_01234567});
      wait_out("bp", 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         a        = $urandom;
         b        = $urandom;
         in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         chk("bp_out_valid_held", {33'd0, out_valid}, 34'd1);
         chk("bp_diff_ext_held", {1'b0, diff_ext}, {1'b0, 33'h0_01234567});
         chk("bp_in_ready_low", {33'd0, in_ready}, 34'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", {33'd0, out_valid}, 34'd0);
      chk("bp_release_ready", {33'd0, in_ready}, 34'd1);
      chk("bp_idle_hold", {1'b0, diff_ext}, {1'b0, 33'h0_01234567});
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("bp_no_second_op", {33'd0, out_valid}, 34'd0);
      end

      // reset two cycles into RUN aborts; in_valid during reset is refused
      @(negedge clk);
      a        = 32'd50;
      b        = 32'd7;
      bin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 32'd1;
      b        = 32'd0;
      @(posedge clk);
      #1;
      chk("abort_out_valid", {33'd0, out_valid}, 34'd0);
      chk("abort_diff_ext", {1'b0, diff_ext}, 34'd0);
      chk("abort_in_ready", {33'd0, in_ready}, 34'd0);
      @(posedge clk);
      #1;
      chk("abort_in_ready_2", {33'd0, in_ready}, 34'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("abort_ready_after", {33'd0, in_ready}, 34'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_valid", {33'd0, out_valid}, 34'd0);
      end
      run_op("after_abort", 32'd100, 32'd1, 1'b0, 33'h0_00000063, 1'b0);

      // signed-overflow vectors
      run_op("ovf_neg_min", 32'h80000000, 32'd1,        1'b0, 33'h0_7FFFFFFF, 1'b1);
      run_op("ovf_pos_max", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 33'h1_80000000, 1'b1);
      run_op("ovf_none",    32'd5,        32'd5,        1'b0, 33'h0_00000000, 1'b0);
      run_op("ovf_pattern", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 33'h0_4B4B4B4B, 1'b1);

      chk("scoreboard_empty", 34'(exp_q.size()), 34'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
